// File: rtl/vga_pkg.sv
// Shared types for the VGA framebuffer write path.
package vga_pkg;

  localparam int unsigned PIX_W = 3;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [9:0]       coord_x_t;
  typedef logic [9:0]       coord_y_t;

  typedef enum logic {ST_IDLE, ST_CLEAR} arb_state_t;

endpackage

// File: rtl/vga_fb_write_arbiter_if.sv
// Packed requester bundle feeding the framebuffer write arbiter.
interface vga_fb_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 10
);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ*X_W-1:0]            req_x;
  logic [NUM_REQ*Y_W-1:0]            req_y;
  logic [NUM_REQ*vga_pkg::PIX_W-1:0] req_pixel;
  logic [NUM_REQ-1:0]                req_ready;

  modport master (output req_valid, req_x, req_y, req_pixel, input  req_ready);
  modport slave  (input  req_valid, req_x, req_y, req_pixel, output req_ready);

endinterface

// File: rtl/vga_fb_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       en,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (en) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/vga_fb_write_arbiter.sv
// Shares the VGA framebuffer write port between requesters and a raster clear sequencer.
module vga_fb_write_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 10
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic [X_W-1:0]         width,
  input  logic [Y_W-1:0]         height,
  input  logic                   tear_free,
  input  logic                   visible_s,
  vga_fb_write_arbiter_if.slave  req_if,
  input  logic                   clear_start,
  input  pixel_t                 clear_color,
  output logic                   clear_busy,
  output logic [X_W-1:0]         fb_x,
  output logic [Y_W-1:0]         fb_y,
  output logic                   fb_wr_en,
  output pixel_t                 fb_pixel,
  output logic                   err_oob
);

  arb_state_t                   state;
  logic                         gate;
  logic                         arb_en;
  logic [NUM_REQ-1:0]           gnt;
  logic [$clog2(NUM_REQ)-1:0]   gnt_idx;
  logic                         hs;
  logic [X_W-1:0]               xs [NUM_REQ];
  logic [Y_W-1:0]               ys [NUM_REQ];
  pixel_t                       ps [NUM_REQ];
  logic [X_W-1:0]               sel_x, cx, w_s;
  logic [Y_W-1:0]               sel_y, cy, h_s;
  pixel_t                       sel_p, color_s;

  assign gate   = !(tear_free && visible_s);
  // clear_start wins over requesters in the cycle it is seen
  assign arb_en = gate && (state == ST_IDLE) && !clear_start;
  assign hs     = |gnt;
  assign req_if.req_ready = gnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .srst    (srst),
    .req     (req_if.req_valid),
    .en      (arb_en),
    .advance (hs),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      xs[k] = req_if.req_x[k*X_W +: X_W];
      ys[k] = req_if.req_y[k*Y_W +: Y_W];
      ps[k] = req_if.req_pixel[k*PIX_W +: PIX_W];
    end
  end

  assign sel_x = xs[gnt_idx];
  assign sel_y = ys[gnt_idx];
  assign sel_p = ps[gnt_idx];

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= ST_IDLE;
      clear_busy <= 1'b0;
      fb_x       <= '0;
      fb_y       <= '0;
      fb_wr_en   <= 1'b0;
      fb_pixel   <= '0;
      err_oob    <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      w_s        <= '0;
      h_s        <= '0;
      color_s    <= '0;
    end else begin
      fb_wr_en <= 1'b0;
      err_oob  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            w_s        <= width;
            h_s        <= height;
            color_s    <= clear_color;
            cx         <= '0;
            cy         <= '0;
            state      <= ST_CLEAR;
            clear_busy <= 1'b1;
          end else if (hs) begin
            if (sel_x < width && sel_y < height) begin
              fb_wr_en <= 1'b1;
              fb_x     <= sel_x;
              fb_y     <= sel_y;
              fb_pixel <= sel_p;
            end else begin
              err_oob <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          // an empty area finishes after a single busy cycle
          if (w_s == '0 || h_s == '0) begin
            state      <= ST_IDLE;
            clear_busy <= 1'b0;
          end else if (gate) begin
            fb_wr_en <= 1'b1;
            fb_x     <= cx;
            fb_y     <= cy;
            fb_pixel <= color_s;
            if (cx == w_s - X_W'(1)) begin
              cx <= '0;
              if (cy == h_s - Y_W'(1)) begin
                cy         <= '0;
                state      <= ST_IDLE;
                clear_busy <= 1'b0;
              end else begin
                cy <= cy + Y_W'(1);
              end
            end else begin
              cx <= cx + X_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Bench for vga_fb_write_arbiter: per-cycle reference model plus directed scenarios with literal checks.
module tb_vga_fb_write_arbiter;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       srst;
  logic [9:0] width;
  logic [9:0] height;
  logic       tear_free, visible_s, clear_start;
  logic [2:0] clear_color;
  logic       clear_busy, fb_wr_en, err_oob;
  logic [9:0] fb_x, fb_y;
  logic [2:0] fb_pixel;

  vga_fb_write_arbiter_if #(.NUM_REQ(N), .X_W(10), .Y_W(10)) rif ();

  vga_fb_write_arbiter #(.NUM_REQ(N), .X_W(10), .Y_W(10)) dut (
    .clk         (clk),
    .srst        (srst),
    .width       (width),
    .height      (height),
    .tear_free   (tear_free),
    .visible_s   (visible_s),
    .req_if      (rif),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_wr_en    (fb_wr_en),
    .fb_pixel    (fb_pixel),
    .err_oob     (err_oob)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear progress is a linear pixel index over the sampled area.
  bit m_valid = 0;
  bit m_clr;
  int m_ptr, m_w, m_h, m_col, m_idx;
  int e_x, e_y, e_pix;
  bit e_we, e_err, e_busy;

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (rif.req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    bit gate;
    int rx, ry, rp;
    if (m_valid) begin
      chk("fb_wr_en", int'(fb_wr_en), int'(e_we));
      chk("err_oob", int'(err_oob), int'(e_err));
      chk("clear_busy", int'(clear_busy), int'(e_busy));
      chk("fb_x", int'(fb_x), e_x);
      chk("fb_y", int'(fb_y), e_y);
      chk("fb_pixel", int'(fb_pixel), e_pix);
    end
    gate = !(tear_free && visible_s);
    g = -1;
    if (!srst && m_valid) begin
      if (!m_clr && !clear_start && gate) g = pick();
      chk("req_ready", int'(rif.req_ready), (g < 0) ? 0 : (1 << g));
    end
    if (srst) begin
      m_valid = 1; m_clr = 0; m_ptr = 0; m_idx = 0;
      e_x = 0; e_y = 0; e_pix = 0; e_we = 0; e_err = 0; e_busy = 0;
    end else if (m_valid) begin
      e_we = 0; e_err = 0;
      if (m_clr) begin
        if (m_w == 0 || m_h == 0) begin
          m_clr = 0;
        end else if (gate) begin
          e_we = 1; e_x = m_idx % m_w; e_y = m_idx / m_w; e_pix = m_col;
          m_idx++;
          if (m_idx == m_w * m_h) m_clr = 0;
        end
      end else if (clear_start) begin
        m_clr = 1; m_w = int'(width); m_h = int'(height); m_col = int'(clear_color); m_idx = 0;
      end else if (g >= 0) begin
        rx = int'(rif.req_x[g*10 +: 10]);
        ry = int'(rif.req_y[g*10 +: 10]);
        rp = int'(rif.req_pixel[g*3 +: 3]);
        if (rx < int'(width) && ry < int'(height)) begin
          e_we = 1; e_x = rx; e_y = ry; e_pix = rp;
        end else begin
          e_err = 1;
        end
        m_ptr = (g + 1) % N;
      end
      e_busy = m_clr;
    end
  end

  // Observation logs for the literal checks.
  typedef struct {int x; int y; int p;} wr_t;
  wr_t wrs[$];
  int  grants[$];
  int  nbusy, nerr;

  task automatic clr_logs();
    wrs.delete(); grants.delete(); nbusy = 0; nerr = 0;
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) if (rif.req_ready[i]) grants.push_back(i);
    if (fb_wr_en) wrs.push_back('{int'(fb_x), int'(fb_y), int'(fb_pixel)});
    if (clear_busy) nbusy++;
    if (err_oob) nerr++;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_req(input int i, input int x, input int y, input int p);
    rif.req_x[i*10 +: 10]  = 10'(x);
    rif.req_y[i*10 +: 10]  = 10'(y);
    rif.req_pixel[i*3 +: 3] = 3'(p);
  endtask

  function automatic int count_col(input int c);
    int n = 0;
    foreach (wrs[i]) if (wrs[i].p == c) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t cw[$];
    bit  seen [6];
    int  dup, bound;

    srst = 1; width = 10'd640; height = 10'd480; tear_free = 0; visible_s = 0;
    clear_start = 0; clear_color = 0;
    rif.req_valid = '0; rif.req_x = '0; rif.req_y = '0; rif.req_pixel = '0;
    steps(3);
    chk("rst_wr_en", int'(fb_wr_en), 0);
    chk("rst_busy", int'(clear_busy), 0);
    chk("rst_err", int'(err_oob), 0);
    chk("rst_x", int'(fb_x), 0);
    srst = 0;
    steps(2);

    // Alternating grants between requesters 0 and 2
    clr_logs();
    set_req(0, 10, 20, 1); set_req(2, 30, 40, 6);
    rif.req_valid = 3'b101;
    steps(4);
    rif.req_valid = '0;
    step();
    chk("rr_ngrant", grants.size(), 4);
    if (grants.size() == 4) begin
      chk("rr_g0", grants[0], 0); chk("rr_g1", grants[1], 2);
      chk("rr_g2", grants[2], 0); chk("rr_g3", grants[3], 2);
    end
    chk("rr_nwr", wrs.size(), 4);
    if (wrs.size() == 4) begin
      chk("rr_w0x", wrs[0].x, 10); chk("rr_w0p", wrs[0].p, 1);
      chk("rr_w1y", wrs[1].y, 40); chk("rr_w1p", wrs[1].p, 6);
    end

    // Bounds: (640,5) dropped with error, (639,479) written
    clr_logs();
    set_req(1, 640, 5, 3); rif.req_valid = 3'b010;
    step(); rif.req_valid = '0; step();
    chk("oob_err", nerr, 1);
    chk("oob_nwr", wrs.size(), 0);
    chk("oob_grant", grants.size(), 1);
    set_req(1, 639, 479, 7); rif.req_valid = 3'b010;
    step(); rif.req_valid = '0; step();
    chk("edge_nwr", wrs.size(), 1);
    if (wrs.size() == 1) begin
      chk("edge_x", wrs[0].x, 639); chk("edge_y", wrs[0].y, 479);
    end
    chk("edge_err", nerr, 1);

    // Tear-free suppression while visible
    clr_logs();
    tear_free = 1; visible_s = 1; set_req(0, 1, 2, 3); rif.req_valid = 3'b001;
    steps(10);
    chk("tf_grants", grants.size(), 0);
    chk("tf_nwr", wrs.size(), 0);
    visible_s = 0;
    step(); rif.req_valid = '0; step();
    chk("tf_release", wrs.size(), 1);
    tear_free = 0;

    // 4x3 clear with requesters pending
    width = 10'd4; height = 10'd3;
    set_req(0, 0, 0, 1); set_req(1, 1, 1, 2); set_req(2, 2, 2, 3);
    rif.req_valid = 3'b111; clear_color = 3'd5; clear_start = 1;
    clr_logs();
    step();
    chk("clr_start_grant", grants.size(), 0);
    clear_start = 0;
    clr_logs();
    steps(12);
    chk("clr_stall", grants.size(), 0);
    steps(3);
    rif.req_valid = '0;
    steps(2);
    chk("clr_busy_cyc", nbusy, 12);
    chk("clr_nwr", count_col(5), 12);
    foreach (wrs[i]) if (wrs[i].p == 5) cw.push_back(wrs[i]);
    if (cw.size() == 12) begin
      chk("clr_w0x", cw[0].x, 0);  chk("clr_w0y", cw[0].y, 0);
      chk("clr_w4x", cw[4].x, 0);  chk("clr_w4y", cw[4].y, 1);
      chk("clr_w11x", cw[11].x, 3); chk("clr_w11y", cw[11].y, 2);
    end
    chk("clr_resume", (grants.size() > 0) ? grants[0] : -1, 1);

    // Zero-width clear
    width = 10'd0; clear_color = 3'd4; clear_start = 1;
    step(); clear_start = 0; clr_logs();
    steps(4);
    chk("z_busy", nbusy, 1);
    chk("z_nwr", wrs.size(), 0);

    // Reset during a clear, just after (2,1) is issued
    width = 10'd4; height = 10'd3; clear_color = 3'd6; clear_start = 1;
    step(); clear_start = 0; clr_logs();
    bound = 0;
    while (wrs.size() < 6 && bound < 30) begin step(); bound++; end
    chk("rst_mid_reach", wrs.size(), 6);
    srst = 1; step(); srst = 0; step();
    chk("rst_mid_we", int'(fb_wr_en), 0);
    chk("rst_mid_busy", int'(clear_busy), 0);
    steps(3);
    chk("rst_mid_nwr", wrs.size(), 7);
    if (wrs.size() == 7) begin
      chk("rst_mid_lx", wrs[6].x, 2); chk("rst_mid_ly", wrs[6].y, 1);
    end

    // Clear paused by tear-free while visible toggles
    width = 10'd3; height = 10'd2; tear_free = 1; visible_s = 0;
    clear_color = 3'd2; clear_start = 1;
    step(); clear_start = 0; clr_logs();
    for (int s = 0; s < 40; s++) begin visible_s = (s % 3 == 0); step(); end
    visible_s = 0; tear_free = 0; steps(2);
    chk("tfc_nwr", count_col(2), 6);
    dup = 0;
    foreach (seen[i]) seen[i] = 0;
    foreach (wrs[i]) if (wrs[i].p == 2 && wrs[i].x < 3 && wrs[i].y < 2) begin
      if (seen[wrs[i].y*3 + wrs[i].x]) dup++;
      seen[wrs[i].y*3 + wrs[i].x] = 1;
    end
    chk("tfc_dup", dup, 0);
    foreach (seen[i]) chk("tfc_cover", int'(seen[i]), 1);
    chk("tfc_paused", int'(nbusy > 6), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_write_arbiter.md
Name: vga_fb_write_arbiter

Overview:
- Shares the single framebuffer pixel-write port (X, Y, wr_en, pixel) of the VGA output block between NUM_REQ requesters using round-robin arbitration.
- Contains a built-in clear sequencer that fills the active area with one colour, one pixel per cycle, replacing the long srst-hold clear.
- Optional tear-free mode: no writes are issued while the display is in its visible region.
- Sits between the drawing masters (CPU bridge, blitter, text engine) and the VGA block's write port.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
X_W, 10, X coordinate width
Y_W, 10, Y coordinate width

Ports:
clk  in  1  system clock (same clock as the VGA block's write port)
srst  in  1  synchronous active-high reset
width  in  X_W  active width in pixels (same value fed to the VGA block)
height  in  Y_W  active height in lines
tear_free  in  1  1 = suppress all writes while visible_s=1
visible_s  in  1  VGA visible flag, already synchronised into clk upstream
req_valid  in  NUM_REQ  per-requester write request
req_x  in  NUM_REQ*X_W  packed X coordinates, requester i at bits [i*X_W +: X_W]
req_y  in  NUM_REQ*Y_W  packed Y coordinates
req_pixel  in  NUM_REQ*3  packed 3-bit colours
req_ready  out  NUM_REQ  one-hot grant; transfer occurs when valid & ready
clear_start  in  1  pulse: start a full-area clear
clear_color  in  3  fill colour, sampled on clear_start
clear_busy  out  1  high while the clear is in progress
fb_x  out  X_W  to VGA X
fb_y  out  Y_W  to VGA Y
fb_wr_en  out  1  to VGA wr_en
fb_pixel  out  3  to VGA pixel
err_oob  out  1  one-cycle pulse: an accepted request was out of bounds and dropped

Behaviour:
- Reset: all outputs 0. State = IDLE. Round-robin pointer = 0. Clear counters = 0.
- All outputs are registered. req_ready is combinational from current state, req_valid and pointer; it never depends on itself.
- States: IDLE (arbitrate requesters) and CLEAR (sequence the fill).
- Write gate: gate = !(tear_free & visible_s). When gate=0:
  - req_ready = 0.
  - The CLEAR counters hold.
  - fb_wr_en = 0 on the next cycle.
- IDLE arbitration:
  - Each cycle with gate=1, grant the first valid requester searching from pointer upward, wrapping modulo NUM_REQ.
  - At most one req_ready bit is high. req_ready is 0 for non-valid requesters.
  - On a handshake with requester g, pointer <= (g+1) mod NUM_REQ. With no handshake, pointer holds.
- Latency: a handshake in cycle N drives fb_wr_en=1 with that requester's x/y/pixel in cycle N+1. Otherwise fb_wr_en=0 in N+1. Back-to-back writes occur at 1 per cycle. fb_x/fb_y/fb_pixel hold their last values when fb_wr_en=0.
- Bounds check: a request with x >= width or y >= height is still accepted (ready=1, consumed). In that case:
  - fb_wr_en stays 0.
  - err_oob pulses in N+1.
  - The pointer still advances.
- clear_start in IDLE:
  - Samples clear_color, width and height.
  - Goes to CLEAR next cycle with cx=0, cy=0.
  - req_ready = 0 in that same cycle. clear_start has priority over requesters.
- clear_start in CLEAR is ignored.
- CLEAR state:
  - clear_busy = 1 (registered; rises the cycle after clear_start).
  - req_ready = 0 for all requesters.
  - Each gated cycle emits fb_wr_en=1 at (cx, cy) with the sampled colour.
  - cx increments. When cx = w_s-1, cx <= 0 and cy increments.
  - After the write at (w_s-1, h_s-1): state <= IDLE and clear_busy <= 0 on the following cycle.
  - A full clear takes exactly w_s*h_s gated cycles.
- Sampled width or height of 0: CLEAR emits no writes, and clear_busy is high for exactly 1 cycle.
- Changes to width/height during CLEAR do not affect the sequence (sampled copies are used). In IDLE, bounds use the live width/height.
- srst mid-clear: the clear aborts immediately. Next cycle: fb_wr_en=0, clear_busy=0, state IDLE.
- Arithmetic: comparisons use full X_W/Y_W unsigned widths. The cx/cy counters are X_W/Y_W bits wide and cannot overflow, since cx < w_s <= 2^X_W-1.

Decomposition:
- Package vga_pkg:
  - PIX_W=3
  - typedef pixel_t (logic [2:0])
  - typedef coord_x_t / coord_y_t (10-bit)
  - typedef enum arb_state_t {ST_IDLE, ST_CLEAR}
- One sub-module: rr_arbiter (NUM_REQ; inputs req, en, advance; outputs one-hot gnt and pointer update). It is reusable elsewhere in the video path.

Test Plan:
- Req0 and req2 valid continuously, NUM_REQ=3, gate=1 -> grants alternate 0,2,0,2. Each fb_wr_en comes 1 cycle after its handshake with the matching x/y/pixel.
- width=640, height=480, req1 writes (640,5) -> accepted, fb_wr_en=0, err_oob=1 for one cycle. (639,479) -> written normally.
- tear_free=1, visible_s=1 for 10 cycles with req0 valid -> req_ready=0 and no writes. When visible_s=0, the write issues the next cycle.
- width=4, height=3, clear_start with clear_color=5 -> 12 writes in raster order (0,0)..(3,2), colour 5. clear_busy is high 12 cycles. Requesters stall during the clear, then resume.
- Clear with width=0 -> zero writes, clear_busy high 1 cycle. Separately, srst asserted mid-clear at (2,1) -> writes stop next cycle, clear_busy=0, IDLE.
- Clear with tear_free=1 and visible_s toggling -> counters pause while visible. Total writes still equal w*h with no duplicates or skips.
